hash_result_fifo: RTL and testbench

HASH_RESULT_FIFO -- requirements
Module: hash_result_fifo

---
 rtl/hash_result_fifo_pkg.sv | 22 ++
 rtl/hash_result_fifo_rr_arbiter.sv | 37 +++
 rtl/hash_result_fifo.sv | 130 +++++++++++++
 tb/tb_hash_result_fifo.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_result_fifo_pkg.sv
// Shared constants for the hash result FIFO: nonce width, read byte-select
// encodings, default depth and a byte-extract helper.
package hash_result_fifo_pkg;

  localparam int NONCE_W       = 32;
  localparam int MACRO_ID_W    = 3;
  localparam int DEFAULT_DEPTH = 4;

  // rd_sel encodings; 0..3 pick nonce bytes little-endian, 4 the macro ID
  localparam logic [2:0] SEL_BYTE0    = 3'd0;
  localparam logic [2:0] SEL_BYTE1    = 3'd1;
  localparam logic [2:0] SEL_BYTE2    = 3'd2;
  localparam logic [2:0] SEL_BYTE3    = 3'd3;
  localparam logic [2:0] SEL_MACRO_ID = 3'd4;

  // Little-endian byte b of a nonce
  function automatic logic [7:0] nonce_byte(input logic [NONCE_W-1:0] n,
                                            input logic [1:0]         b);
    return n[8*b +: 8];
  endfunction

endpackage

// File: rtl/hash_result_fifo_rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index unmasked requester at or
// after ptr, wrapping around N. Purely combinational.
module rr_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [N-1:0] eligible;

  assign eligible = req & ~mask;

  // Scan from the farthest offset back to ptr so the nearest eligible wins
  always_comb begin
    int k;
    k       = 0;
    grant   = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      k = (int'(ptr) + off) % N;
      if (eligible[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        gnt_idx  = IDX_W'(k);
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_result_fifo.sv
// Hash result FIFO: collects nonce solutions from NUM_OF_MACROS hash macros
// through a round-robin arbiter into a DEPTH-entry FIFO that is read out a
// byte at a time by the register bank.
// Optional feature: define HASH_RESULT_MACRO_ID_EN to store the source macro
// index with each entry and read it back at rd_sel==4.
module hash_result_fifo
  import hash_result_fifo_pkg::*;
#(
  parameter int NUM_OF_MACROS = 8,
  parameter int DEPTH         = DEFAULT_DEPTH
) (
  input  logic                              iCLK,
  input  logic                              RST,
  input  logic [NUM_OF_MACROS-1:0]          sol_valid,
  input  logic [NONCE_W*NUM_OF_MACROS-1:0]  sol_nonce,
  output logic [NUM_OF_MACROS-1:0]          sol_ack,
  input  logic [2:0]                        rd_sel,
  input  logic                              read_strobe,
  input  logic                              pop,
  output logic [7:0]                        data_out,
  output logic [4:0]                        count,
  output logic                              interrupt_out
);

  localparam int IDX_W = (NUM_OF_MACROS > 1) ? $clog2(NUM_OF_MACROS) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [IDX_W-1:0]         rr_ptr;
  logic [IDX_W-1:0]         gnt_idx;
  logic [NUM_OF_MACROS-1:0] grant;
  logic                     gnt_vld;
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic                     full;
  logic                     empty;
  logic                     do_push;
  logic                     do_pop;
  logic [NONCE_W-1:0]       push_nonce;
  logic [7:0]               rd_byte;

  logic [NONCE_W-1:0]       nonce_mem [DEPTH];
`ifdef HASH_RESULT_MACRO_ID_EN
  logic [MACRO_ID_W-1:0]    id_mem    [DEPTH];
`endif

  // The macro acked last cycle may still hold sol_valid; sol_ack doubles as
  // the arbitration mask so it cannot be captured twice.
  rr_arbiter #(
    .N     (NUM_OF_MACROS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (sol_valid),
    .mask    (sol_ack),
    .ptr     (rr_ptr),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign full    = (count == 5'(DEPTH));
  assign empty   = (count == 5'd0);
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot the new entry lands in
  assign do_push = gnt_vld & (~full | pop);

  // Select the granted macro's nonce
  always_comb begin
    push_nonce = '0;
    for (int i = 0; i < NUM_OF_MACROS; i++) begin
      if (grant[i]) push_nonce = sol_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  // Head-entry byte for the register bank; empty or unknown selects read 0
  always_comb begin
    rd_byte = 8'h00;
    if (!empty) begin
      case (rd_sel)
        SEL_BYTE0:    rd_byte = nonce_byte(nonce_mem[head], 2'd0);
        SEL_BYTE1:    rd_byte = nonce_byte(nonce_mem[head], 2'd1);
        SEL_BYTE2:    rd_byte = nonce_byte(nonce_mem[head], 2'd2);
        SEL_BYTE3:    rd_byte = nonce_byte(nonce_mem[head], 2'd3);
`ifdef HASH_RESULT_MACRO_ID_EN
        SEL_MACRO_ID: rd_byte = {{(8-MACRO_ID_W){1'b0}}, id_mem[head]};
`else
        SEL_MACRO_ID: rd_byte = 8'h00;
`endif
        default:      rd_byte = 8'h00;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here
  always_ff @(posedge iCLK) begin
    if (!RST && do_push) begin
      nonce_mem[tail] <= push_nonce;
`ifdef HASH_RESULT_MACRO_ID_EN
      id_mem[tail]    <= MACRO_ID_W'(gnt_idx);
`endif
    end
  end

  // Pointers, occupancy, ack pulse, round-robin pointer and read register
  always_ff @(posedge iCLK) begin
    if (RST) begin
      head          <= '0;
      tail          <= '0;
      count         <= 5'd0;
      rr_ptr        <= '0;
      sol_ack       <= '0;
      data_out      <= 8'h00;
      interrupt_out <= 1'b0;
    end else begin
      sol_ack <= do_push ? grant : '0;
      if (do_push) begin
        tail   <= tail + 1'b1;
        rr_ptr <= (gnt_idx == IDX_W'(NUM_OF_MACROS - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (do_pop) head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      interrupt_out <= ~empty;
      if (read_strobe) data_out <= rd_byte;
    end
  end

endmodule

// File: tb/tb_hash_result_fifo.sv
// Self-checking bench for hash_result_fifo: directed corner sequences with a
// read-back vector table, then randomized traffic against a queue model.
module tb_hash_result_fifo;

  localparam int N = 8;
  localparam int D = 4;

`ifdef HASH_RESULT_MACRO_ID_EN
  localparam logic [7:0] ID_EXP3 = 8'h03;
  localparam logic [7:0] ID_EXP6 = 8'h06;
`else
  localparam logic [7:0] ID_EXP3 = 8'h00;
  localparam logic [7:0] ID_EXP6 = 8'h00;
`endif

  logic            iCLK = 1'b0;
  logic            RST  = 1'b1;
  logic [N-1:0]    sol_valid = '0;
  logic [32*N-1:0] sol_nonce = '0;
  logic [N-1:0]    sol_ack;
  logic [2:0]      rd_sel = 3'd0;
  logic            read_strobe = 1'b0;
  logic            pop = 1'b0;
  logic [7:0]      data_out;
  logic [4:0]      count;
  logic            interrupt_out;

  hash_result_fifo #(.NUM_OF_MACROS(N), .DEPTH(D)) dut (
    .iCLK          (iCLK),
    .RST           (RST),
    .sol_valid     (sol_valid),
    .sol_nonce     (sol_nonce),
    .sol_ack       (sol_ack),
    .rd_sel        (rd_sel),
    .read_strobe   (read_strobe),
    .pop           (pop),
    .data_out      (data_out),
    .count         (count),
    .interrupt_out (interrupt_out)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          idx;
    logic [31:0] nonce;
  } ent_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] exp;
  } rd_vec_t;

  ent_t         q[$];
  int           m_rr = 0;
  logic [N-1:0] m_ack = '0;
  logic [7:0]   m_data = 8'h00;
  logic         m_irq = 1'b0;
  logic [N-1:0] drop_next = '0;
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_byte(input logic [2:0] sel);
    if (q.size() == 0) return 8'h00;
    if (sel < 3'd4) return 8'((q[0].nonce >> (8 * int'(sel))) & 32'hFF);
`ifdef HASH_RESULT_MACRO_ID_EN
    if (sel == 3'd4) return 8'(q[0].idx);
`endif
    return 8'h00;
  endfunction

  function automatic logic [31:0] nonce_of(input int i);
    return 32'hC0DE0000 + 32'(i) * 32'h111;
  endfunction

  // Macros hold sol_valid for the ack cycle itself, then drop it
  task automatic macros();
    for (int i = 0; i < N; i++) begin
      if (drop_next[i]) begin
        sol_valid[i] = 1'b0;
        drop_next[i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) if (m_ack[i]) drop_next[i] = 1'b1;
  endtask

  task automatic raise(input int i, input logic [31:0] n);
    sol_nonce[32*i +: 32] = n;
    sol_valid[i] = 1'b1;
  endtask

  task automatic clear_macros();
    sol_valid = '0;
    drop_next = '0;
  endtask

  // One clock: model the cycle from the applied inputs, then compare
  task automatic step();
    int   k;
    int   cnt0;
    logic acc;
    cnt0 = q.size();
    k = -1;
    for (int off = 0; off < N; off++) begin
      int c;
      c = (m_rr + off) % N;
      if (k < 0 && sol_valid[c] && !m_ack[c]) k = c;
    end
    acc = (k >= 0) && (cnt0 < D || pop);
    if (read_strobe) m_data = m_byte(rd_sel);
    if (pop && cnt0 > 0) void'(q.pop_front());
    m_ack = '0;
    if (acc) begin
      q.push_back('{k, sol_nonce[32*k +: 32]});
      m_rr = (k + 1) % N;
      m_ack[k] = 1'b1;
    end
    m_irq = (cnt0 != 0);
    @(posedge iCLK); #1;
    chk("ack",   32'(sol_ack),       32'(m_ack));
    chk("count", 32'(count),         32'(q.size()));
    chk("data",  32'(data_out),      32'(m_data));
    chk("irq",   32'(interrupt_out), 32'(m_irq));
    pop = 1'b0;
    read_strobe = 1'b0;
    macros();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge iCLK); #1;
    q.delete();
    m_rr = 0;
    m_ack = '0;
    m_data = 8'h00;
    m_irq = 1'b0;
    chk("rst_count", 32'(count),         32'd0);
    chk("rst_irq",   32'(interrupt_out), 32'd0);
    chk("rst_ack",   32'(sol_ack),       32'd0);
    chk("rst_data",  32'(data_out),      32'd0);
    RST = 1'b0;
    pop = 1'b0;
    read_strobe = 1'b0;
    macros();
  endtask

  initial begin
    rd_vec_t     rd_tab[8];
    logic [31:0] n1;

    rd_tab[0] = '{3'd0, 8'hEF};
    rd_tab[1] = '{3'd1, 8'hBE};
    rd_tab[2] = '{3'd2, 8'hAD};
    rd_tab[3] = '{3'd3, 8'hDE};
    rd_tab[4] = '{3'd4, ID_EXP3};
    rd_tab[5] = '{3'd5, 8'h00};
    rd_tab[6] = '{3'd7, 8'h00};
    rd_tab[7] = '{3'd1, 8'hBE};

    // Single solution and byte read-back
    do_reset();
    raise(3, 32'hDEADBEEF);
    step();
    chk("s1_ack", 32'(sol_ack), 32'h08);
    chk("s1_cnt", 32'(count),   32'd1);
    step();
    chk("s1_irq", 32'(interrupt_out), 32'd1);
    chk("s1_cnt_hold", 32'(count), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rd_sel = rd_tab[i].sel;
      read_strobe = 1'b1;
      step();
      chk("rd_tab", 32'(data_out), 32'(rd_tab[i].exp));
    end

    // Fairness up to full, then full push+pop
    clear_macros();
    do_reset();
    for (int i = 0; i < N; i++) raise(i, nonce_of(i));
    for (int s = 0; s < 7; s++) begin
      step();
      chk("fair_ack", 32'(sol_ack), (s < 4) ? (32'd1 << s) : 32'd0);
    end
    chk("full_cnt", 32'(count), 32'd4);
    pop = 1'b1;
    step();
    chk("pp_cnt", 32'(count),   32'd4);
    chk("pp_ack", 32'(sol_ack), 32'h10);
    rd_sel = 3'd0;
    read_strobe = 1'b1;
    step();
    n1 = nonce_of(1);
    chk("pp_rd", 32'(data_out), 32'(n1[7:0]));

    // Empty pop and empty read
    clear_macros();
    do_reset();
    pop = 1'b1;
    read_strobe = 1'b1;
    rd_sel = 3'd2;
    step();
    chk("e_cnt",  32'(count),         32'd0);
    chk("e_data", 32'(data_out),      32'd0);
    chk("e_irq",  32'(interrupt_out), 32'd0);
    step();
    chk("e_irq2", 32'(interrupt_out), 32'd0);

    // Reset with three entries held; macro 5 recaptured afterwards
    raise(0, 32'h11111111);
    raise(1, 32'h22222222);
    raise(2, 32'h33333333);
    step();
    step();
    step();
    chk("r_cnt3", 32'(count), 32'd3);
    raise(5, 32'h55555555);
    do_reset();
    chk("r_cnt0", 32'(count),         32'd0);
    chk("r_irq0", 32'(interrupt_out), 32'd0);
    step();
    chk("r_ack5", 32'(sol_ack), 32'h20);

    // Macro-ID readback
    clear_macros();
    do_reset();
    raise(6, 32'h12345678);
    step();
    step();
    rd_sel = 3'd4;
    read_strobe = 1'b1;
    step();
    chk("id6", 32'(data_out), 32'(ID_EXP6));

    // Randomized traffic
    clear_macros();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!sol_valid[i] && $urandom_range(0, 3) == 0) raise(i, $urandom());
      pop = ($urandom_range(0, 2) == 0);
      read_strobe = $urandom_range(0, 1) == 1;
      rd_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
